vga_mode_scheduler: RTL and testbench

Sequences display-mode changes for the VGA subsystem. It synchronises and debounces the raw mode slide switch, then defers every Lock-in/FFT mode change to a frame boundary signalled by the VGA controller. It also forces the colour outputs to black for a programmable number of whole frames around the change. It sits between the board switch and the visualizer output multiplexer, in the pixel clock domain.

---
 rtl/vga_mode_scheduler.sv | 148 ++++++++++++++
 tb/tb_vga_mode_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_scheduler.sv
// vga_mode_scheduler
// Synchronises and debounces the Lock-in/FFT slide switch, defers each
// accepted mode change to the next frame boundary, then holds the colour
// outputs black for BLANK_FRAMES whole frames after the change.
module vga_mode_scheduler #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int BLANK_FRAMES    = 2,
    parameter int FRM_W           = 4
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic i_switch_mode,
    input  logic i_frame_over,
    output logic o_mode,
    output logic o_force_blank,
    output logic o_mode_change,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Last blank frame index; unused when blanking is disabled.
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
    localparam bit               BLANK_EN = (BLANK_FRAMES > 0);

    typedef enum logic [1:0] {
        ST_STABLE     = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BLANK      = 2'd2
    } state_t;

    logic             r_sw_s1;
    logic             r_sw_sync;
    logic             r_sw_db;
    logic [CNT_W-1:0] r_db_cnt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_force_blank;
    logic             w_force_blank_nxt;
    logic             r_mode_change;
    logic             w_mode_change_nxt;
    logic             r_busy;
    logic [FRM_W-1:0] r_frm_cnt;
    logic [FRM_W-1:0] w_frm_cnt_nxt;

    // Two-flop synchroniser for the asynchronous slide switch.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_sw_s1   <= 1'b0;
            r_sw_sync <= 1'b0;
        end else begin
            r_sw_s1   <= i_switch_mode;
            r_sw_sync <= r_sw_s1;
        end
    end

    // Debounce: accept the synced level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_sw_db  <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sw_sync == r_sw_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_sw_db  <= r_sw_sync;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Next-state and registered-output logic of the mode-change sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_mode_nxt        = r_mode;
        w_force_blank_nxt = r_force_blank;
        w_mode_change_nxt = 1'b0;
        w_frm_cnt_nxt     = r_frm_cnt;
        case (r_state)
            ST_STABLE: begin
                // A frame pulse coinciding with the mismatch is deliberately
                // not used: the change waits for a full frame boundary.
                if (r_sw_db != r_mode) begin
                    w_state_nxt = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                // Withdrawal wins over a coincident frame pulse.
                if (r_sw_db == r_mode) begin
                    w_state_nxt = ST_STABLE;
                end else if (i_frame_over) begin
                    w_mode_nxt        = r_sw_db;
                    w_mode_change_nxt = 1'b1;
                    w_frm_cnt_nxt     = '0;
                    if (BLANK_EN) begin
                        w_force_blank_nxt = 1'b1;
                        w_state_nxt       = ST_BLANK;
                    end else begin
                        w_state_nxt = ST_STABLE;
                    end
                end
            end
            ST_BLANK: begin
                // Switch activity is ignored here; STABLE re-evaluates on entry.
                if (i_frame_over) begin
                    w_frm_cnt_nxt = r_frm_cnt + 1'b1;
                    if (r_frm_cnt == FRM_LAST) begin
                        w_force_blank_nxt = 1'b0;
                        w_state_nxt       = ST_STABLE;
                    end
                end
            end
            default: begin
                w_state_nxt       = ST_STABLE;
                w_force_blank_nxt = 1'b0;
            end
        endcase
    end

    // State register with outputs registered alongside it.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_STABLE;
            r_mode        <= 1'b0;
            r_force_blank <= 1'b0;
            r_mode_change <= 1'b0;
            r_busy        <= 1'b0;
            r_frm_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_mode        <= w_mode_nxt;
            r_force_blank <= w_force_blank_nxt;
            r_mode_change <= w_mode_change_nxt;
            r_busy        <= (w_state_nxt != ST_STABLE);
            r_frm_cnt     <= w_frm_cnt_nxt;
        end
    end

    assign o_mode        = r_mode;
    assign o_force_blank = r_force_blank;
    assign o_mode_change = r_mode_change;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_vga_mode_scheduler.sv
// Self-checking bench for vga_mode_scheduler with a short debounce and
// 2-frame blanking; compares every cycle against a behavioural model.
module tb_vga_mode_scheduler;

    localparam int DEB   = 4;
    localparam int BLANK = 2;

    logic clk;
    logic reset;
    logic sw;
    logic man_fo;
    logic gen_fo;
    logic fo;
    logic frame_en;
    int   frame_period;
    int   fcnt;

    logic o_mode;
    logic o_force_blank;
    logic o_mode_change;
    logic o_busy;

    int n_checks;
    int n_errors;

    // Behavioural model state
    logic m_s1;
    logic m_sync;
    logic m_db;
    int   m_run;
    logic m_mode;
    logic m_change;
    logic m_pending;
    int   m_blank_left;

    assign fo = gen_fo | man_fo;

    vga_mode_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .BLANK_FRAMES   (BLANK),
        .FRM_W          (4)
    ) dut (
        .pixel_clk    (clk),
        .reset        (reset),
        .i_switch_mode(sw),
        .i_frame_over (fo),
        .o_mode       (o_mode),
        .o_force_blank(o_force_blank),
        .o_mode_change(o_mode_change),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Periodic frame-end pulse generator
    always @(negedge clk) begin
        if (!frame_en) begin
            gen_fo <= 1'b0;
            fcnt   <= 0;
        end else if (fcnt >= frame_period - 1) begin
            gen_fo <= 1'b1;
            fcnt   <= 0;
        end else begin
            gen_fo <= 1'b0;
            fcnt   <= fcnt + 1;
        end
    end

    // Reference model: a level is accepted after DEB consecutive disagreeing
    // synced samples; a request is pending until a frame pulse, after which
    // BLANK frame pulses must pass before another request is considered.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1         <= 1'b0;
            m_sync       <= 1'b0;
            m_db         <= 1'b0;
            m_run        <= 0;
            m_mode       <= 1'b0;
            m_change     <= 1'b0;
            m_pending    <= 1'b0;
            m_blank_left <= 0;
        end else begin
            m_s1   <= sw;
            m_sync <= m_s1;
            if (m_sync == m_db) begin
                m_run <= 0;
            end else if (m_run + 1 == DEB) begin
                m_db  <= m_sync;
                m_run <= 0;
            end else begin
                m_run <= m_run + 1;
            end

            m_change <= 1'b0;
            if (m_blank_left > 0) begin
                if (fo) m_blank_left <= m_blank_left - 1;
            end else if (m_pending) begin
                if (m_db == m_mode) begin
                    m_pending <= 1'b0;
                end else if (fo) begin
                    m_mode       <= m_db;
                    m_change     <= 1'b1;
                    m_pending    <= 1'b0;
                    m_blank_left <= BLANK;
                end
            end else if (m_db != m_mode) begin
                m_pending <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("mode",   int'(o_mode),        int'(m_mode));
        check("blank",  int'(o_force_blank), int'(m_blank_left > 0));
        check("change", int'(o_mode_change), int'(m_change));
        check("busy",   int'(o_busy),        int'(m_pending || (m_blank_left > 0)));
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        man_fo = 1'b1;
        @(negedge clk);
        man_fo = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b0;
        sw           = 1'b1;
        man_fo       = 1'b0;
        frame_en     = 1'b1;
        frame_period = 50;

        // Reset held with switch high: outputs must stay low
        wait_cyc(5);
        check("rst_mode",   int'(o_mode),        0);
        check("rst_blank",  int'(o_force_blank), 0);
        check("rst_change", int'(o_mode_change), 0);
        check("rst_busy",   int'(o_busy),        0);
        reset = 1'b1;
        wait_cyc(200);
        check("post_rst_mode", int'(o_mode), 1);

        // Full change back to Lock-in
        sw = 1'b0;
        wait_cyc(200);
        check("lockin_mode", int'(o_mode), 0);

        // Short glitch must be rejected
        sw = 1'b1;
        wait_cyc(3);
        sw = 1'b0;
        wait_cyc(60);
        check("glitch_mode", int'(o_mode), 0);

        // Full change to FFT
        sw = 1'b1;
        wait_cyc(200);
        check("fft_mode", int'(o_mode), 1);

        // Withdrawal with no frame pulses
        frame_en = 1'b0;
        wait_cyc(2);
        sw = 1'b0;
        wait_cyc(12);
        check("wd_busy", int'(o_busy), 1);
        sw = 1'b1;
        wait_cyc(15);
        check("wd_idle", int'(o_busy), 0);
        check("wd_mode", int'(o_mode), 1);

        // Switch toggles during blanking
        sw = 1'b0;
        wait_cyc(12);
        pulse_frame();
        wait_cyc(5);
        sw = 1'b1;
        wait_cyc(10);
        pulse_frame();
        wait_cyc(5);
        pulse_frame();
        wait_cyc(5);
        check("reeval_busy", int'(o_busy), 1);
        pulse_frame();
        wait_cyc(3);
        check("pre_rst_blank", int'(o_force_blank), 1);
        check("pre_rst_mode",  int'(o_mode),        1);

        // Asynchronous reset mid-blank: outputs drop without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check("async_blank", int'(o_force_blank), 0);
        check("async_mode",  int'(o_mode),        0);
        check("async_busy",  int'(o_busy),        0);
        @(negedge clk);
        reset = 1'b1;
        frame_en = 1'b1;
        wait_cyc(200);

        // Randomised switch activity and frame periods
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) frame_period = $urandom_range(10, 60);
            sw = 1'($urandom_range(0, 1));
            wait_cyc($urandom_range(1, 60));
        end
        wait_cyc(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
